// File: rtl/mcc_pkg.sv
// Shared MCC types and constants: state encoding, crossbar sizing, saturating add.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcc_pkg;

    localparam int STATE_WIDTH   = 5;
    localparam int MCC_DATA_W    = 32;
    localparam int MCC_XBAR_SIZE = 32;
    localparam int MCC_SEL_W     = $clog2(MCC_XBAR_SIZE);

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE   = 5'd0,
        ST_LOAD   = 5'd1,
        ST_PROG   = 5'd2,
        ST_SETTLE = 5'd3,
        ST_SENSE  = 5'd4,
        ST_CHECK  = 5'd5,
        ST_DONE   = 5'd6
    } xbar_state_t;

    // Unsigned amplitude plus signed correction, clamped to [0, 2^W-1].
    // Two guard bits: the top one flags a negative sum, the next one an overflow.
    function automatic logic [MCC_DATA_W-1:0] sat_add(
        input logic        [MCC_DATA_W-1:0] a,
        input logic signed [MCC_DATA_W:0]   d
    );
        logic signed [MCC_DATA_W+1:0] s;
        s = $signed({2'b00, a}) + $signed({d[MCC_DATA_W], d});
        if (s[MCC_DATA_W+1])
            return '0;
        else if (s[MCC_DATA_W])
            return '1;
        else
            return s[MCC_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/xbar_prog_ctrl_if.sv
// Target stream, DAC/mux and ADC signals between the sequencer and the analog front end.
// Latency: n/a (wiring only).
// Backpressure: tgt_valid/tgt_ready on the target stream; sense_req held until adc_valid.
interface xbar_prog_ctrl_if
    import mcc_pkg::*;
#(
    parameter int DATA_W = MCC_DATA_W,
    parameter int SEL_W  = MCC_SEL_W
);
    logic              tgt_valid;
    logic [DATA_W-1:0] tgt_data;
    logic              tgt_ready;
    logic              dac_en;
    logic [DATA_W-1:0] dac_data;
    logic [SEL_W-1:0]  mux_sel;
    logic              sense_req;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;

    // Sequencer side
    modport master (
        input  tgt_valid, tgt_data, adc_valid, adc_data,
        output tgt_ready, dac_en, dac_data, mux_sel, sense_req
    );

    // Controller / analog front-end side
    modport slave (
        output tgt_valid, tgt_data, adc_valid, adc_data,
        input  tgt_ready, dac_en, dac_data, mux_sel, sense_req
    );
endinterface

// File: rtl/xbar_err_calc.sv
// Program-verify error: signed target-minus-reading, tolerance flag, saturated next amplitude.
// Latency: combinational.
// Backpressure: none.
module xbar_err_calc
    import mcc_pkg::*;
#(
    parameter int TOL = 4
) (
    input  logic [MCC_DATA_W-1:0] tgt,
    input  logic [MCC_DATA_W-1:0] adc,
    input  logic [MCC_DATA_W-1:0] amp,
    output logic                  in_tol,
    output logic [MCC_DATA_W-1:0] amp_nxt
);
    localparam logic signed [MCC_DATA_W:0] TOL_S = (MCC_DATA_W+1)'(TOL);

    // One extra bit keeps the full unsigned difference range representable.
    logic signed [MCC_DATA_W:0] err;

    assign err     = $signed({1'b0, tgt}) - $signed({1'b0, adc});
    assign in_tol  = (err <= TOL_S) && (err >= -TOL_S);
    assign amp_nxt = sat_add(amp, err);
endmodule

// File: rtl/xbar_prog_ctrl.sv
// Crossbar program-and-verify sequencer: loads targets, then pulses/senses each cell until in tolerance.
// Latency: per iteration PROG 1 + SETTLE_CYC + SENSE (>=1) + CHECK 1 cycles; done one cycle after last CHECK.
// Backpressure: tgt_ready only in LOAD; SENSE waits indefinitely for adc_valid; start ignored while busy.
module xbar_prog_ctrl
    import mcc_pkg::*;
#(
    parameter int XBAR_SIZE  = MCC_XBAR_SIZE,
    parameter int SEL_W      = MCC_SEL_W,
    parameter int DATA_W     = MCC_DATA_W,   // datapath math is sized by MCC_DATA_W; keep equal
    parameter int ITER_MAX   = 5,
    parameter int TOL        = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    xbar_prog_ctrl_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic [XBAR_SIZE-1:0] fail_map
);
    localparam int ITER_W = $clog2(ITER_MAX + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    xbar_state_t       state, state_nxt;
    logic [DATA_W-1:0] tgt_arr [XBAR_SIZE];
    logic [SEL_W-1:0]  load_cnt;
    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  idx_inc;
    logic [ITER_W-1:0] iter;
    logic [SET_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] amp;
    logic [DATA_W-1:0] adc_q;
    logic [DATA_W-1:0] amp_nxt;
    logic              tgt_ready_q, dac_en_q, sense_req_q;
    logic              accept, load_last, last_cell, cell_end, in_tol;

    assign accept    = bus.tgt_valid && (state == ST_LOAD);
    assign load_last = (load_cnt == SEL_W'(XBAR_SIZE - 1));
    assign last_cell = (idx == SEL_W'(XBAR_SIZE - 1));
    assign cell_end  = in_tol || (iter == ITER_W'(ITER_MAX));
    assign idx_inc   = idx + 1'b1;

    xbar_err_calc #(
        .TOL (TOL)
    ) u_err_calc (
        .tgt     (tgt_arr[idx]),
        .adc     (adc_q),
        .amp     (amp),
        .in_tol  (in_tol),
        .amp_nxt (amp_nxt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   if (accept && load_last) state_nxt = ST_PROG;
            ST_PROG:   state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = ST_SENSE;
            ST_SENSE:  if (bus.adc_valid) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (cell_end && last_cell) ? ST_DONE : ST_PROG;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Target store, cell/iteration counters, amplitude and fail map
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < XBAR_SIZE; i++)
                tgt_arr[i] <= '0;
            load_cnt   <= '0;
            idx        <= '0;
            iter       <= '0;
            settle_cnt <= '0;
            amp        <= '0;
            adc_q      <= '0;
            fail_map   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fail_map <= '0;
                        load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        tgt_arr[load_cnt] <= bus.tgt_data;
                        load_cnt          <= load_cnt + 1'b1;
                        if (load_last) begin
                            idx  <= '0;
                            iter <= '0;
                            // cell 0 is only already stored when it is not also the last target
                            amp  <= (load_cnt == '0) ? bus.tgt_data : tgt_arr[0];
                        end
                    end
                end
                ST_PROG: begin
                    iter       <= iter + 1'b1;
                    settle_cnt <= '0;
                end
                ST_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                ST_SENSE: begin
                    if (bus.adc_valid)
                        adc_q <= bus.adc_data;
                end
                ST_CHECK: begin
                    if (cell_end) begin
                        if (!in_tol)
                            fail_map[idx] <= 1'b1;
                        if (!last_cell) begin
                            idx  <= idx_inc;
                            iter <= '0;
                            amp  <= tgt_arr[idx_inc];
                        end
                    end else begin
                        amp <= amp_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered strobes, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_ready_q <= 1'b0;
            dac_en_q    <= 1'b0;
            sense_req_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            tgt_ready_q <= (state_nxt == ST_LOAD);
            dac_en_q    <= (state_nxt == ST_PROG);
            sense_req_q <= (state_nxt == ST_SENSE);
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
        end
    end

    assign bus.tgt_ready = tgt_ready_q;
    assign bus.dac_en    = dac_en_q;
    assign bus.dac_data  = amp;
    assign bus.mux_sel   = idx;
    assign bus.sense_req = sense_req_q;
endmodule
